// File: rtl/branch_predictor_if.sv
// Fetch/Execute signal bundle between the core datapath and branch_predictor.
// The master modport is the datapath side. The slave modport is the predictor side.
interface branch_predictor_if;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredPCF;
    logic [31:0] PredTargetF;

    logic [1:0]  BranchOpE;
    logic        PCSrcE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [31:0] PCTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;

    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    modport master (
        output PCF, BranchOpE, PCSrcE, PCE, PCPlus4E, PCTargetE, PredTakenE, PredTargetE,
        input  PredTakenF, PredPCF, PredTargetF, MispredictE, RedirectPCE,
               BranchCount, MispredictCount
    );

    modport slave (
        input  PCF, BranchOpE, PCSrcE, PCE, PCPlus4E, PCTargetE, PredTakenE, PredTargetE,
        output PredTakenF, PredPCF, PredTargetF, MispredictE, RedirectPCE,
               BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts in Fetch and resolves and trains in Execute.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int unsigned ENTRIES = 2 ** INDEX_WIDTH;
    localparam int unsigned TAG_W   = 30 - INDEX_WIDTH;

    localparam logic [1:0] OP_JUMP   = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    logic [INDEX_WIDTH-1:0] w_f_idx;
    logic [TAG_W-1:0]       w_f_tag;
    logic                   w_f_hit;
    logic                   w_f_taken;

    logic [INDEX_WIDTH-1:0] w_e_idx;
    logic [TAG_W-1:0]       w_e_tag;
    logic                   w_e_tag_match;
    logic                   w_e_hit;
    logic                   w_e_is_br;
    logic                   w_e_taken;
    logic                   w_mispredict;

    logic                   w_wr_en;
    logic                   w_wr_valid;
    logic [31:0]            w_wr_target;
    logic [1:0]             w_wr_ctr;

    logic                   w_unused_pce_lsb;

    assign w_unused_pce_lsb = ^bp.PCE[1:0];

    // Fetch lookup
    assign w_f_idx   = bp.PCF[INDEX_WIDTH+1:2];
    assign w_f_tag   = bp.PCF[31:INDEX_WIDTH+2];
    assign w_f_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken = w_f_hit && r_ctr[w_f_idx][1];

    assign bp.PredTakenF  = w_f_taken;
    assign bp.PredPCF     = w_f_taken ? r_target[w_f_idx] : bp.PCF + 32'd4;
    assign bp.PredTargetF = w_f_hit ? r_target[w_f_idx] : 32'd0;

    // Execute resolution; opcodes 00 and 11 are non-branches and PCSrcE is ignored for them
    assign w_e_idx       = bp.PCE[INDEX_WIDTH+1:2];
    assign w_e_tag       = bp.PCE[31:INDEX_WIDTH+2];
    assign w_e_tag_match = (r_tag[w_e_idx] == w_e_tag);
    assign w_e_hit       = r_valid[w_e_idx] && w_e_tag_match;
    assign w_e_is_br     = (bp.BranchOpE == OP_JUMP) || (bp.BranchOpE == OP_BRANCH);
    assign w_e_taken     = w_e_is_br && bp.PCSrcE;

    always_comb begin
        w_mispredict = 1'b0;
        if (w_e_is_br && (bp.PCSrcE != bp.PredTakenE)) begin
            w_mispredict = 1'b1;
        end
        if (w_e_taken && bp.PredTakenE && (bp.PredTargetE != bp.PCTargetE)) begin
            w_mispredict = 1'b1;
        end
        if (!w_e_is_br && bp.PredTakenE) begin
            w_mispredict = 1'b1;
        end
    end

    assign bp.MispredictE = w_mispredict;
    assign bp.RedirectPCE = w_e_taken ? bp.PCTargetE : bp.PCPlus4E;

    // Next contents of the Execute-indexed entry
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_valid  = r_valid[w_e_idx];
        w_wr_target = r_target[w_e_idx];
        w_wr_ctr    = r_ctr[w_e_idx];
        case (bp.BranchOpE)
            OP_BRANCH: begin
                if (w_e_hit) begin
                    w_wr_en = 1'b1;
                    if (bp.PCSrcE) begin
                        w_wr_target = bp.PCTargetE;
                        if (r_ctr[w_e_idx] != 2'b11) begin
                            w_wr_ctr = r_ctr[w_e_idx] + 2'd1;
                        end
                    end else if (r_ctr[w_e_idx] != 2'b00) begin
                        w_wr_ctr = r_ctr[w_e_idx] - 2'd1;
                    end
                end else if (bp.PCSrcE) begin
                    w_wr_en     = 1'b1;
                    w_wr_valid  = 1'b1;
                    w_wr_target = bp.PCTargetE;
                    w_wr_ctr    = 2'b10;
                end
            end
            OP_JUMP: begin
                w_wr_en     = 1'b1;
                w_wr_valid  = 1'b1;
                w_wr_target = bp.PCTargetE;
                w_wr_ctr    = 2'b11;
            end
            default: begin
                // A non-branch at a PC the BTB claims as a branch: drop the stale entry
                if (w_e_tag_match) begin
                    w_wr_en    = 1'b1;
                    w_wr_valid = 1'b0;
                end
            end
        endcase
    end

    // Table storage; reset takes priority over any Execute update in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_wr_en) begin
            r_valid[w_e_idx]  <= w_wr_valid;
            r_tag[w_e_idx]    <= w_e_tag;
            r_target[w_e_idx] <= w_wr_target;
            r_ctr[w_e_idx]    <= w_wr_ctr;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_e_is_br) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign bp.BranchCount     = r_branch_cnt;
    assign bp.MispredictCount = r_mispred_cnt;
`else
    assign bp.BranchCount     = 32'd0;
    assign bp.MispredictCount = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor, checked against a table-level reference model.
module tb_branch_predictor;
    localparam int unsigned N = 64;
`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    branch_predictor_if u_if ();

    branch_predictor #(.INDEX_WIDTH(6)) dut (.clk(clk), .reset(reset), .bp(u_if));

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    bit          m_valid  [N];
    int unsigned m_tag    [N];
    int unsigned m_target [N];
    int unsigned m_ctr    [N];
    bit [31:0]   m_bc, m_mc;
    bit          m_mis;

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % N;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / (4 * N);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs and check every output against the model at the falling edge
    task automatic drive(input bit rst, input int unsigned pcf, input bit [1:0] op, input bit src,
                         input int unsigned pce, input int unsigned tgt, input bit pt,
                         input int unsigned ptg);
        int unsigned fi;
        bit hit, taken, is_br;
        reset             = rst;
        u_if.PCF          = pcf;
        u_if.BranchOpE    = op;
        u_if.PCSrcE       = src;
        u_if.PCE          = pce;
        u_if.PCPlus4E     = pce + 4;
        u_if.PCTargetE    = tgt;
        u_if.PredTakenE   = pt;
        u_if.PredTargetE  = ptg;
        @(negedge clk);
        fi    = idx_of(pcf);
        hit   = m_valid[fi] && (m_tag[fi] == tag_of(pcf));
        taken = hit && (m_ctr[fi] >= 2);
        is_br = (op == 2'b01) || (op == 2'b10);
        m_mis = (is_br && (src != pt)) || (is_br && src && pt && (ptg != tgt)) || (!is_br && pt);
        chk("PredTakenF", 32'(u_if.PredTakenF), 32'(taken));
        chk("PredPCF", u_if.PredPCF, taken ? m_target[fi] : pcf + 4);
        chk("PredTargetF", u_if.PredTargetF, hit ? m_target[fi] : 0);
        chk("MispredictE", 32'(u_if.MispredictE), 32'(m_mis));
        chk("RedirectPCE", u_if.RedirectPCE, (is_br && src) ? tgt : pce + 4);
        chk("BranchCount", u_if.BranchCount, STATS ? m_bc : 32'd0);
        chk("MispredictCount", u_if.MispredictCount, STATS ? m_mc : 32'd0);
    endtask

    // Advance through the rising edge, applying the table rules to the model
    task automatic tick();
        int unsigned ei;
        bit [1:0] op;
        @(posedge clk);
        op = u_if.BranchOpE;
        ei = idx_of(u_if.PCE);
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
            end
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (op == 2'b01 || op == 2'b10) m_bc++;
            if (m_mis) m_mc++;
            if (op == 2'b10) begin
                if (m_valid[ei] && m_tag[ei] == tag_of(u_if.PCE)) begin
                    if (u_if.PCSrcE) begin
                        m_target[ei] = u_if.PCTargetE;
                        if (m_ctr[ei] < 3) m_ctr[ei]++;
                    end else if (m_ctr[ei] > 0) begin
                        m_ctr[ei]--;
                    end
                end else if (u_if.PCSrcE) begin
                    m_valid[ei] = 1; m_tag[ei] = tag_of(u_if.PCE);
                    m_target[ei] = u_if.PCTargetE; m_ctr[ei] = 2;
                end
            end else if (op == 2'b01) begin
                m_valid[ei] = 1; m_tag[ei] = tag_of(u_if.PCE);
                m_target[ei] = u_if.PCTargetE; m_ctr[ei] = 3;
            end else if (m_tag[ei] == tag_of(u_if.PCE)) begin
                m_valid[ei] = 0;
            end
        end
        #1;
    endtask

    task automatic bubble(input int unsigned pcf);
        drive(0, pcf, 2'b00, 0, 32'hFFFF_FF00, 0, 0, 0);
    endtask

    initial begin
        int unsigned pool_pc, pool_f, tg, fi;
        bit [1:0] op;
        bit use_model, rst;

        reset = 1'b1;
        u_if.PCF = 0; u_if.BranchOpE = 0; u_if.PCSrcE = 0; u_if.PCE = 0;
        u_if.PCPlus4E = 4; u_if.PCTargetE = 0; u_if.PredTakenE = 0; u_if.PredTargetE = 0;
        m_mis = 0;
        tick();
        tick();

        // Post-reset lookup
        bubble(32'h100);
        chk("reset_predpc", u_if.PredPCF, 32'h104);
        chk("reset_taken", 32'(u_if.PredTakenF), 32'd0);
        tick();

        // First taken branch allocates
        drive(0, 32'h100, 2'b10, 1, 32'h100, 32'h80, 0, 0);
        chk("alloc_mis", 32'(u_if.MispredictE), 32'd1);
        chk("alloc_redirect", u_if.RedirectPCE, 32'h80);
        tick();
        bubble(32'h100);
        chk("alloc_predpc", u_if.PredPCF, 32'h80);
        tick();

        // Train down: 10 -> 01 -> 00 -> 00, then up twice
        for (int k = 0; k < 3; k++) begin
            drive(0, 32'h100, 2'b10, 0, 32'h100, 32'h80, u_if.PredTakenF, u_if.PredTargetF);
            tick();
            bubble(32'h100);
            chk("ntaken_predict", 32'(u_if.PredTakenF), 32'd0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 32'h100, 2'b10, 1, 32'h100, 32'h80, 0, 0);
            tick();
        end
        bubble(32'h100);
        chk("retrain_taken", 32'(u_if.PredTakenF), 32'd1);
        tick();

        // Jump with wrong predicted target, aliasing onto index 0
        drive(0, 32'h100, 2'b01, 1, 32'h200, 32'h300, 1, 32'h2F0);
        chk("jump_mis", 32'(u_if.MispredictE), 32'd1);
        chk("jump_redirect", u_if.RedirectPCE, 32'h300);
        tick();
        bubble(32'h200);
        chk("jump_target", u_if.PredTargetF, 32'h300);
        tick();
        bubble(32'h100);
        chk("evicted_miss", u_if.PredTargetF, 32'd0);
        tick();

        // Non-branch predicted taken: mispredict to PC+4 and invalidate
        drive(0, 32'h200, 2'b00, 1, 32'h200, 32'h300, 1, 32'h300);
        chk("nonbr_mis", 32'(u_if.MispredictE), 32'd1);
        chk("nonbr_redirect", u_if.RedirectPCE, 32'h204);
        tick();
        bubble(32'h200);
        chk("nonbr_invalid", 32'(u_if.PredTakenF), 32'd0);
        tick();

        // Statistics: 10 branches with 3 mispredicts
        drive(1, 0, 2'b00, 0, 32'hFFFF_FF00, 0, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(0, 32'h400, 2'b10, 1, 32'h400, 32'h480, (k % 3) != 1, 32'h480);
            tick();
        end
        bubble(32'h400);
        chk("stat_branches", u_if.BranchCount, STATS ? 32'd10 : 32'd0);
        chk("stat_mispred", u_if.MispredictCount, STATS ? 32'd3 : 32'd0);
        tick();

        // Reset wins over a branch in E, mispredict still combinational
        drive(1, 32'h500, 2'b10, 1, 32'h500, 32'h600, 0, 0);
        chk("rst_mis_comb", 32'(u_if.MispredictE), 32'd1);
        tick();
        bubble(32'h500);
        chk("rst_no_update", 32'(u_if.PredTakenF), 32'd0);
        chk("rst_counts", u_if.BranchCount, 32'd0);
        tick();

        // Randomized traffic over a small aliasing PC pool
        for (int n = 0; n < 600; n++) begin
            pool_pc = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            pool_f  = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            case ($urandom_range(0, 2))
                0: tg = 32'h80;
                1: tg = 32'h300;
                default: tg = 32'h1000;
            endcase
            op        = 2'($urandom_range(0, 3));
            use_model = $urandom_range(0, 1) == 1;
            rst       = $urandom_range(0, 39) == 0;
            fi        = idx_of(pool_pc);
            if (use_model) begin
                if (m_valid[fi] && m_tag[fi] == tag_of(pool_pc))
                    drive(rst, pool_f, op, 1'($urandom_range(0, 1)), pool_pc, tg,
                          m_ctr[fi] >= 2, m_target[fi]);
                else
                    drive(rst, pool_f, op, 1'($urandom_range(0, 1)), pool_pc, tg, 0, 0);
            end else begin
                drive(rst, pool_f, op, 1'($urandom_range(0, 1)), pool_pc, tg,
                      1'($urandom_range(0, 1)), (n % 2 == 0) ? tg : 32'h2F0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Fetch-stage branch predictor and Execute-stage misprediction resolver for the pipelined RV32I core.
- Fetch: direct-mapped branch target buffer (BTB) with 2-bit saturating counters supplies a predicted next PC.
- Execute: compares the prediction against the branch decoder's resolved PCSrcE, trains the table, and raises a redirect to the hazard unit on mismatch.

## Interface
Parameters:
- INDEX_WIDTH, 6, log2 of BTB entry count (64 entries); index = PC[INDEX_WIDTH+1:2], tag = PC[31:INDEX_WIDTH+2]

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- PCF  in  32  Fetch-stage PC
- PredTakenF  out  1  prediction for PCF: taken
- PredPCF  out  32  predicted next PC for PCF
- PredTargetF  out  32  BTB target for PCF (0 on miss); pipelined to E by datapath
- BranchOpE  in  2  00 non-branch, 01 jump, 10 conditional branch
- PCSrcE  in  1  resolved taken from branch decoder
- PCE, PCPlus4E, PCTargetE  in  32 each  Execute PC, PC+4, resolved target
- PredTakenE  in  1  PredTakenF carried to E
- PredTargetE  in  32  PredTargetF carried to E
- MispredictE  out  1  redirect request to hazard unit (flush D/E)
- RedirectPCE  out  32  correct next PC when MispredictE=1
- BranchCount, MispredictCount  out  32 each  statistics (see Configuration)

## Operation
- Entry fields: Valid, Tag[31-INDEX_WIDTH-2:0], Target[31:0], Ctr[1:0].
- Lookup (combinational on PCF):
  - HitF = Valid && Tag match.
  - PredTakenF = HitF && Ctr[1].
  - PredPCF = PredTakenF ? Target : PCF+4.
  - PredTargetF = HitF ? Target : 0.
- Resolution (combinational in E):
  - MispredictE = (BranchOpE!=00 && PCSrcE!=PredTakenE) || (PCSrcE && PredTakenE && PredTargetE!=PCTargetE) || (BranchOpE==00 && PredTakenE).
  - RedirectPCE = PCSrcE ? PCTargetE : PCPlus4E.
  - PCSrcE is ignored when BranchOpE==00 (redirect goes to PCPlus4E).
- Update on rising edge, indexed by PCE:
  - BranchOpE==10, hit: Ctr saturating +1 if PCSrcE, else -1 (floor 00, ceiling 11); Target<=PCTargetE if PCSrcE.
  - BranchOpE==10, miss, PCSrcE=1: allocate (Valid=1, Tag, Target=PCTargetE, Ctr=10), overwriting any occupant.
  - BranchOpE==10, miss, PCSrcE=0: no write.
  - BranchOpE==01: allocate/overwrite with Ctr=11, Target=PCTargetE.
  - BranchOpE==00 and E-index entry tag-matches PCE: clear Valid.
  - BranchOpE==11: treated as 00.
- Flushed E bubbles must arrive with BranchOpE=00 and PredTakenE=0; no update, no mispredict.

## Timing
- Reset (synchronous): all Valid=0, Ctr=01, Tag/Target=0; counters cleared. Next cycle PredTakenF=0, PredPCF=PCF+4, MispredictE=0 (given bubble inputs).
- Lookup and resolution: 0-cycle latency (combinational).
- Update is visible to lookup the cycle after the E edge. Same-index F read and E write in one cycle: F sees the old entry.
- Reset asserted with a branch in E: reset wins, no update is written. MispredictE still follows E inputs combinationally.
- No stall input: E never stalls; F stalls only hold PCF.

## Configuration
- BP_STATS_EN defined:
  - BranchCount increments each cycle BranchOpE is 01 or 10.
  - MispredictCount increments each cycle MispredictE=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both outputs are constant 0 and no counter flops exist.

## Test plan
- Reset, then PCF=0x100 -> PredTakenF=0, PredPCF=0x104, PredTargetF=0.
- E: PCE=0x100, BranchOpE=10, PCSrcE=1, PCTargetE=0x80, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x100 -> PredTakenF=1, PredPCF=0x80.
- Same branch resolved not-taken twice (Ctr 10->01->00) -> PredTakenF=0 after the first; a third not-taken holds Ctr=00; two taken restore PredTakenF=1.
- Jump PCE=0x200, PCTargetE=0x300, PredTakenE=1, PredTargetE=0x2F0 -> MispredictE=1, RedirectPCE=0x300, entry Target becomes 0x300.
- Aliasing: entries for 0x100 and 0x200 (same index with INDEX_WIDTH=6) -> second allocation evicts first; PCF=0x100 then misses. BranchOpE=00 with PredTakenE=1 -> MispredictE=1, RedirectPCE=PCPlus4E, entry invalidated.
- With BP_STATS_EN: 10 branches including 3 mispredicts -> BranchCount=10, MispredictCount=3; reset mid-run returns both to 0.
